// File: rtl/bus_req_pkg.sv
// Shared types and constants for the bus requester: the FSM state encoding, the
// preemption counter width and its saturating increment.
package bus_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_t;

  localparam int PREEMPT_W = 8;

  function automatic logic [PREEMPT_W-1:0] sat_inc(input logic [PREEMPT_W-1:0] v);
    return (&v) ? v : v + PREEMPT_W'(1);
  endfunction

endpackage

// File: rtl/bus_req_timer.sv
// Stall counter: counts enabled cycles and flags the cycle on which the count would
// reach TIMEOUT, so the owner can act on that same clock edge.
module bus_req_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // The TIMEOUT-th stalled cycle is the one that expires, not the cycle after it.
  assign expired = en & ~clear & (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_requester.sv
// Requester-side client of a 2-port round-robin arbiter: accepts a burst command,
// requests the bus, streams beats while granted (surviving preemption), then releases.
module bus_requester
  import bus_req_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 req,
  input  logic                 gnt,
  output logic                 bus_valid,
  output logic [DATA_W-1:0]    bus_data,
  output logic                 bus_last,
  output logic                 done,
  output logic                 abort,
  output logic [PREEMPT_W-1:0] preempt_cnt
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             gnt_q;
  logic             in_xfer;
  logic             stall;
  logic             beat;
  logic             last_beat;
  logic             preempt;
  logic             timeout;

  assign in_xfer   = (state == XFER);
  assign stall     = ((state == REQ) | in_xfer) & ~gnt;
  assign cmd_ready = (state == IDLE);

  // Beat path is combinational from gnt so a granted cycle is never wasted.
  assign wr_ready  = in_xfer & gnt;
  assign beat      = wr_ready & wr_valid;
  assign last_beat = beat & (remaining == '0);
  assign bus_valid = beat;
  assign bus_data  = beat ? wr_data : '0;
  assign bus_last  = last_beat;
  assign preempt   = in_xfer & gnt_q & ~gnt;

  bus_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (~stall),
    .en      (stall),
    .expired (timeout)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req         <= 1'b0;
      remaining   <= '0;
      gnt_q       <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
      preempt_cnt <= '0;
    end else begin
      gnt_q <= gnt;
      done  <= 1'b0;
      abort <= 1'b0;

      if (preempt) begin
        preempt_cnt <= sat_inc(preempt_cnt);
      end

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            state       <= REQ;
            req         <= 1'b1;
            remaining   <= cmd_len;
            preempt_cnt <= '0;
          end
        end

        REQ: begin
          if (gnt) begin
            state <= XFER;
          end else if (timeout) begin
            state <= REL;
            req   <= 1'b0;
            abort <= 1'b1;
          end
        end

        XFER: begin
          if (last_beat) begin
            state <= REL;
            req   <= 1'b0;
            done  <= 1'b1;
          end else if (beat) begin
            remaining <= remaining - LEN_W'(1);
          end else if (timeout) begin
            state <= REL;
            req   <= 1'b0;
            abort <= 1'b1;
          end
        end

        REL: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_done_abort_excl : assert property (@(posedge clk) disable iff (rst) !(done && abort));
  a_beat_needs_req  : assert property (@(posedge clk) disable iff (rst) bus_valid |-> req);

endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester: a per-cycle vector table, directed corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_bus_requester;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 64;

  localparam int P_IDLE   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STREAM = 2;
  localparam int P_REL    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              done;
  logic              abort;
  logic [7:0]        preempt_cnt;

  bus_requester #(
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .req         (req),
    .gnt         (gnt),
    .bus_valid   (bus_valid),
    .bus_data    (bus_data),
    .bus_last    (bus_last),
    .done        (done),
    .abort       (abort),
    .preempt_cnt (preempt_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              cv;
    logic [LEN_W-1:0]  len;
    logic              g;
    logic              wv;
    logic [DATA_W-1:0] d;
    logic [46:0]       exp;  // {req,cmd_ready,wr_ready,bus_valid,bus_last,done,abort,bus_data,preempt_cnt}
  } vec_t;

  function automatic vec_t mk(input logic cv, input logic [3:0] len, input logic g, input logic wv,
                              input logic [31:0] d, input logic e_req, input logic e_crdy,
                              input logic e_wrdy, input logic e_bv, input logic e_last,
                              input logic e_done);
    vec_t v;
    v.cv  = cv;
    v.len = len;
    v.g   = g;
    v.wv  = wv;
    v.d   = d;
    v.exp = {e_req, e_crdy, e_wrdy, e_bv, e_last, e_done, 1'b0, (e_bv ? d : 32'd0), 8'd0};
    return v;
  endfunction

  // ---------------- reference model ----------------
  int          m_phase, m_left, m_stall, m_pre;
  logic        m_done, m_abort, m_gprev;
  logic [31:0] beats[$];
  int          done_cnt;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_left  = 0;
    m_stall = 0;
    m_pre   = 0;
    m_done  = 1'b0;
    m_abort = 1'b0;
    m_gprev = 1'b0;
  endtask

  task automatic stall_tick();
    m_stall++;
    if (m_stall == TIMEOUT) begin
      m_abort = 1'b1;
      m_phase = P_REL;
    end
  endtask

  task automatic model_step(input logic cv, input logic [3:0] len, input logic g, input logic wv);
    m_done  = 1'b0;
    m_abort = 1'b0;
    case (m_phase)
      P_IDLE: if (cv) begin
        m_phase = P_WAIT;
        m_left  = int'(len) + 1;
        m_stall = 0;
        m_pre   = 0;
      end
      P_WAIT: if (g) begin
        m_stall = 0;
        m_phase = P_STREAM;
      end else stall_tick();
      P_STREAM: if (g) begin
        m_stall = 0;
        if (wv) begin
          m_left--;
          if (m_left == 0) begin
            m_done  = 1'b1;
            m_phase = P_REL;
          end
        end
      end else begin
        if (m_gprev && m_pre < 255) m_pre++;
        stall_tick();
      end
      default: m_phase = P_IDLE;
    endcase
    m_gprev = g;
  endtask

  // Entered at posedge+1: drive, sample at posedge+4, step the model on the edge.
  task automatic cycle(input logic cv, input logic [3:0] len, input logic g, input logic wv,
                       input logic [31:0] d);
    logic e_bv;
    cmd_valid = cv;
    cmd_len   = len;
    gnt       = g;
    wr_valid  = wv;
    wr_data   = d;
    #3;
    e_bv = (m_phase == P_STREAM) && g && wv;
    check("req",         64'(req),         64'((m_phase == P_WAIT) || (m_phase == P_STREAM)));
    check("cmd_ready",   64'(cmd_ready),   64'(m_phase == P_IDLE));
    check("wr_ready",    64'(wr_ready),    64'((m_phase == P_STREAM) && g));
    check("bus_valid",   64'(bus_valid),   64'(e_bv));
    check("bus_data",    64'(bus_data),    64'(e_bv ? d : 32'd0));
    check("bus_last",    64'(bus_last),    64'(e_bv && (m_left == 1)));
    check("done",        64'(done),        64'(m_done));
    check("abort",       64'(abort),       64'(m_abort));
    check("preempt_cnt", 64'(preempt_cnt), 64'(m_pre));
    if (bus_valid) beats.push_back(bus_data);
    if (done) done_cnt++;
    @(posedge clk);
    model_step(cv, len, g, wv);
    cyc++;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int   k;
    int   gap;
    int   starve;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    gnt       = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_req",         64'(req),         64'(0));
    check("rst_done_abort",  64'({done, abort}), 64'(0));
    check("rst_preempt_cnt", 64'(preempt_cnt), 64'(0));
    check("rst_cmd_ready",   64'(cmd_ready),   64'(1));
    rst = 1'b0;

    // 4-beat burst with grant one cycle after req, then single-beat, then bubbled burst
    vecs.push_back(mk(1, 3, 0, 0, 32'h0,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hA0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hA0,  1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hA1,  1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hA2,  1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hA3,  1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hA4,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hB0,  1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 32'h0,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hC0,  1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'hC1,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hC1,  1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'hC2,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hC2,  1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'hC3,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hC3,  1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   0, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      cmd_valid = vecs[i].cv;
      cmd_len   = vecs[i].len;
      gnt       = vecs[i].g;
      wr_valid  = vecs[i].wv;
      wr_data   = vecs[i].d;
      #3;
      check($sformatf("vec[%0d]", i),
            64'({req, cmd_ready, wr_ready, bus_valid, bus_last, done, abort, bus_data, preempt_cnt}),
            64'(vecs[i].exp));
      @(posedge clk);
      cyc++;
      #1;
    end

    // 8-beat burst, grant withdrawn for 3 cycles after the third beat
    model_reset();
    beats.delete();
    done_cnt = 0;
    gap      = 0;
    cycle(1, 7, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    for (int n = 0; n < 40 && done_cnt == 0; n++) begin
      logic g;
      g = !(beats.size() == 3 && gap < 3);
      if (!g) gap++;
      cycle(0, 0, g, 1, 32'hD000_0000 + 32'(beats.size()));
    end
    check("preempt_done_seen", 64'(done_cnt), 64'(1));
    check("preempt_beat_count", 64'(beats.size()), 64'(8));
    foreach (beats[i]) check($sformatf("preempt_beat[%0d]", i), 64'(beats[i]), 64'(32'hD000_0000 + i));
    check("preempt_cnt_after", 64'(preempt_cnt), 64'(1));

    // grant never arrives: abort after TIMEOUT stalled cycles
    beats.delete();
    cycle(1, 5, 0, 1, 32'hE5);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0, 0, 1, 32'hE5);
      k++;
      if (abort) break;
    end
    check("abort_latency", 64'(k), 64'(TIMEOUT));
    check("abort_req_low", 64'(req), 64'(0));
    cycle(0, 0, 0, 0, 32'h0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    check("abort_no_beats", 64'(beats.size()), 64'(0));

    // reset while beat 2 of a 6-beat burst is on the bus
    cycle(1, 5, 0, 0, 32'h0);
    cycle(0, 0, 1, 1, 32'hF000_0000);
    cycle(0, 0, 1, 1, 32'hF000_0000);
    cycle(0, 0, 1, 1, 32'hF000_0001);
    gnt      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'hF000_0002;
    #2;
    check("rst_mid_beat_valid", 64'(bus_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("rst_mid_req", 64'(req), 64'(0));
    check("rst_mid_bus_valid", 64'(bus_valid), 64'(0));
    @(posedge clk);
    cyc++;
    #1;
    check("rst_mid_no_pulse", 64'({done, abort}), 64'(0));
    rst = 1'b0;
    model_reset();
    beats.delete();
    done_cnt = 0;
    cycle(1, 2, 0, 0, 32'h0);
    for (int n = 0; n < 10 && done_cnt == 0; n++) begin
      cycle(0, 0, 1, 1, 32'h5A00_0000 + 32'(beats.size()));
    end
    check("post_rst_done", 64'(done_cnt), 64'(1));
    check("post_rst_beats", 64'(beats.size()), 64'(3));
    check("post_rst_first", 64'(beats.size() > 0 ? beats[0] : 32'hFFFF_FFFF), 64'(32'h5A00_0000));
    check("post_rst_preempt", 64'(preempt_cnt), 64'(0));

    // randomized traffic with occasional grant starvation
    starve = 0;
    for (int n = 0; n < 3000; n++) begin
      logic g;
      if (starve == 0 && $urandom_range(0, 299) == 0) starve = TIMEOUT + 6;
      if (starve > 0) begin
        g = 1'b0;
        starve--;
      end else begin
        g = ($urandom_range(0, 3) != 0);
      end
      cycle($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), g,
            $urandom_range(0, 3) != 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
